cancid_stream_ctx: RTL

Parametrised per-stream context manager for one DFA regex matcher in the kraaken DPI core. It saves and restores DFA state per stream ID across packets and registers all DFA inputs and outputs for timing. It tracks a per-packet speculative match and commits a saturating match count at end of packet. It is the next-generation replacement for the fixed 64-stream / 11-bit per-regex wrappers: the DFA is external, width and depth are parameters, and stream-validity tracking, write/read bypass and count clear are added.

---
 rtl/kraaken_dpi_pkg.sv | 22 ++
 rtl/cancid_ctx_mem.sv | 55 +++++
 rtl/cancid_stream_ctx.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/kraaken_dpi_pkg.sv
// Shared definitions for the kraaken DPI regex context blocks: default widths,
// the per-stream context record and a saturating increment helper.
package kraaken_dpi_pkg;

  localparam int unsigned STATE_W_DEF     = 11;
  localparam int unsigned NUM_STREAMS_DEF = 64;
  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned DFA_LAT_DEF     = 1;

  typedef struct packed {
    logic                   valid;
    logic [STATE_W_DEF-1:0] state;
  } ctx_rec_t;

  // Counters up to 32 bits wide share this; callers pass their own all-ones limit.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val,
                                          input logic        inc);
    return (inc && (val != max_val)) ? val + 32'd1 : val;
  endfunction

endpackage

// File: rtl/cancid_ctx_mem.sv
// Per-stream DFA state store: NUM_STREAMS x STATE_W memory plus reset-able valid
// bits, one write port and one combinational read port with write->read bypass.
module cancid_ctx_mem #(
  parameter int unsigned STATE_W     = 11,
  parameter int unsigned NUM_STREAMS = 64,
  parameter int unsigned SID_W       = $clog2(NUM_STREAMS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [SID_W-1:0]   wr_sid,
  input  logic [STATE_W-1:0] wr_state,
  input  logic [SID_W-1:0]   rd_sid,
  output logic               rd_valid,
  output logic [STATE_W-1:0] rd_state
);

  typedef struct packed {
    logic               valid;
    logic [STATE_W-1:0] state;
  } ctx_t;

  logic [STATE_W-1:0]     mem_q [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] valid_q;
  logic [NUM_STREAMS-1:0] valid_d;
  ctx_t                   rd_ctx;

  always_comb begin
    valid_d = valid_q;
    if (wr_en) valid_d[wr_sid] = 1'b1;
  end

  // Only the valid bits are reset; stale state words are masked by them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_sid] <= wr_state;
  end

  always_comb begin
    rd_ctx.valid = valid_q[rd_sid];
    rd_ctx.state = mem_q[rd_sid];
    if (wr_en && (wr_sid == rd_sid)) begin
      rd_ctx.valid = 1'b1;
      rd_ctx.state = wr_state;
    end
  end

  assign rd_valid = rd_ctx.valid;
  assign rd_state = rd_ctx.state;

endmodule

// File: rtl/cancid_stream_ctx.sv
// Per-stream context manager for one external DFA: registers DFA I/O, restores and
// saves DFA state per stream, tracks a speculative match and commits a match count.
module cancid_stream_ctx
  import kraaken_dpi_pkg::*;
#(
  parameter int unsigned STATE_W     = STATE_W_DEF,
  parameter int unsigned NUM_STREAMS = NUM_STREAMS_DEF,
  parameter int unsigned SID_W       = $clog2(NUM_STREAMS),
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned DFA_LAT     = DFA_LAT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_state,
  input  logic               new_stream_id,
  input  logic [SID_W-1:0]   stream_id,
  input  logic               enable,
  input  logic [7:0]         char_in,
  input  logic               char_in_vld,
  input  logic               eop,
  input  logic               count_clr,
  output logic [7:0]         dfa_char,
  output logic               dfa_char_vld,
  output logic [STATE_W-1:0] dfa_state_in,
  output logic               dfa_state_in_vld,
  input  logic [STATE_W-1:0] dfa_state_out,
  input  logic               dfa_accept,
  output logic [CNT_W-1:0]   count,
  output logic               count_sat,
  output logic               fired
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  typedef struct packed {
    logic             eop;
    logic             en;
    logic [SID_W-1:0] sid;
  } eop_dly_t;

  logic [7:0]         dfa_char_q, dfa_char_d;
  logic               dfa_char_vld_q, dfa_char_vld_d;
  logic [STATE_W-1:0] dfa_state_in_q, dfa_state_in_d;
  logic               dfa_state_in_vld_q, dfa_state_in_vld_d;
  logic [STATE_W-1:0] state_out_r_q, state_out_r_d;
  logic               accept_r_q, accept_r_d;
  logic               spec_q, spec_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               count_sat_q, count_sat_d;
  eop_dly_t           dly_q [DFA_LAT+1];
  eop_dly_t           dly_d [DFA_LAT+1];

  logic               commit;
  logic               commit_en;
  logic [SID_W-1:0]   sid_d;
  logic               rd_valid;
  logic [STATE_W-1:0] rd_state;
  logic [CNT_W-1:0]   cnt_inc;

  // eop/enable/stream_id ride DFA_LAT+1 stages so commit lines up with accept_r
  // of the packet's last character.
  always_comb begin
    dly_d[0] = '{eop: eop, en: enable, sid: stream_id};
    for (int unsigned i = 1; i <= DFA_LAT; i++) dly_d[i] = dly_q[i-1];
  end

  assign commit    = dly_q[DFA_LAT].eop;
  assign commit_en = commit & dly_q[DFA_LAT].en;
  assign sid_d     = dly_q[DFA_LAT].sid;

  cancid_ctx_mem #(
    .STATE_W     (STATE_W),
    .NUM_STREAMS (NUM_STREAMS),
    .SID_W       (SID_W)
  ) u_ctx_mem (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (commit_en),
    .wr_sid   (sid_d),
    .wr_state (state_out_r_q),
    .rd_sid   (stream_id),
    .rd_valid (rd_valid),
    .rd_state (rd_state)
  );

  always_comb begin
    dfa_char_d         = char_in_vld ? char_in : dfa_char_q;
    dfa_char_vld_d     = char_in_vld;
    dfa_state_in_vld_d = load_state;
    dfa_state_in_d     = dfa_state_in_q;
    if (load_state) dfa_state_in_d = (new_stream_id || !rd_valid) ? '0 : rd_state;
    state_out_r_d      = dfa_state_out;
    accept_r_d         = dfa_accept;
  end

  // A disabled commit discards the packet's match even if its last char accepted.
  always_comb begin
    spec_d = spec_q;
    if (load_state)            spec_d = 1'b0;
    if (accept_r_q)            spec_d = 1'b1;
    if (commit && !commit_en)  spec_d = 1'b0;
  end

  always_comb begin
    cnt_inc     = CNT_W'(sat_inc(32'(count_q), CNT_MAX, spec_q | accept_r_q));
    count_d     = count_q;
    count_sat_d = count_sat_q;
    if (commit_en) begin
      count_d     = cnt_inc;
      count_sat_d = count_sat_q | (&cnt_inc);
    end
    if (count_clr) begin
      count_d     = '0;
      count_sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dfa_char_q         <= '0;
      dfa_char_vld_q     <= 1'b0;
      dfa_state_in_q     <= '0;
      dfa_state_in_vld_q <= 1'b0;
      state_out_r_q      <= '0;
      accept_r_q         <= 1'b0;
      spec_q             <= 1'b0;
      count_q            <= '0;
      count_sat_q        <= 1'b0;
      for (int unsigned i = 0; i <= DFA_LAT; i++) dly_q[i] <= '0;
    end else begin
      dfa_char_q         <= dfa_char_d;
      dfa_char_vld_q     <= dfa_char_vld_d;
      dfa_state_in_q     <= dfa_state_in_d;
      dfa_state_in_vld_q <= dfa_state_in_vld_d;
      state_out_r_q      <= state_out_r_d;
      accept_r_q         <= accept_r_d;
      spec_q             <= spec_d;
      count_q            <= count_d;
      count_sat_q        <= count_sat_d;
      dly_q              <= dly_d;
    end
  end

  assign dfa_char         = dfa_char_q;
  assign dfa_char_vld     = dfa_char_vld_q;
  assign dfa_state_in     = dfa_state_in_q;
  assign dfa_state_in_vld = dfa_state_in_vld_q;
  assign count            = count_q;
  assign count_sat        = count_sat_q;
  assign fired            = spec_q;

endmodule
